// File: rtl/hazard_tag_pipe_if.sv
// Handshake bundle between the ID stage and the hazard/tag tracker.
// The ID side drives instruction tags; the tracker returns stall and forwarding tags.
interface hazard_tag_pipe_if #(
  parameter int RA_W = 5
);
  logic [RA_W-1:0] id_rs_i;
  logic [RA_W-1:0] id_rt_i;
  logic [RA_W-1:0] id_rd_i;
  logic            id_wb_i;
  logic            id_memrd_i;
  logic            id_memwr_i;
  logic            id_use_rt_i;
  logic            flush_i;
  logic            mem_busy_i;
  logic            stall_o;
  logic            bubble_o;
  logic [RA_W-1:0] ExMem_rd_o;
  logic            ExMem_Wb_o;
  logic [RA_W-1:0] MemWb_rd_o;
  logic            MemWb_Wb_o;
  logic            err_o;

  modport master (
    output id_rs_i, id_rt_i, id_rd_i,
    output id_wb_i, id_memrd_i, id_memwr_i,
    output id_use_rt_i, flush_i, mem_busy_i,
    input  stall_o, bubble_o,
    input  ExMem_rd_o, ExMem_Wb_o,
    input  MemWb_rd_o, MemWb_Wb_o, err_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_rd_i,
    input  id_wb_i, id_memrd_i, id_memwr_i,
    input  id_use_rt_i, flush_i, mem_busy_i,
    output stall_o, bubble_o,
    output ExMem_rd_o, ExMem_Wb_o,
    output MemWb_rd_o, MemWb_Wb_o, err_o
  );
endinterface

// File: rtl/hazard_tag_pipe.sv
// Destination-tag tracker for EX/MEM/WB with load-use and
// data-memory wait-state stall/bubble generation.
module hazard_tag_pipe #(
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_tag_pipe_if.slave  bus
);
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            wb;
    logic            mr;
    logic            mw;
  } tag_t;

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam int            CW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  tag_t            ex_q, ex_d;
  tag_t            mem_q, mem_d;
  tag_t            wb_q, wb_d;
  tag_t            id_tag;
  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            mem_acc;
  logic            freeze;
  logic            hit_rs;
  logic            hit_rt;
  logic            lu;
  logic            stall;
  logic            bubble;

  always_comb begin
    mem_acc = mem_q.mr | mem_q.mw;
    freeze  = (st_q == MEM_WAIT)
            | ((st_q == RUN) & mem_acc & bus.mem_busy_i);
    hit_rs  = (ex_q.rd == bus.id_rs_i);
    hit_rt  = bus.id_use_rt_i & (ex_q.rd == bus.id_rt_i);
    lu      = ex_q.mr & ex_q.wb & (ex_q.rd != '0)
            & (hit_rs | hit_rt);
  end

  // A non-writing instruction carries rd=0 so it never matches a source.
  always_comb begin
    id_tag.rd = bus.id_wb_i ? bus.id_rd_i : '0;
    id_tag.wb = bus.id_wb_i;
    id_tag.mr = bus.id_memrd_i;
    id_tag.mw = bus.id_memwr_i;
  end

  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    stall  = 1'b0;
    bubble = 1'b0;
    priority case (1'b1)
      freeze: begin
        stall = 1'b1;
      end
      bus.flush_i: begin
        bubble = 1'b1;
        wb_d   = mem_q;
        mem_d  = ex_q;
        ex_d   = '0;
      end
      lu: begin
        stall  = 1'b1;
        bubble = 1'b1;
        wb_d   = mem_q;
        mem_d  = ex_q;
        ex_d   = '0;
      end
      default: begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = id_tag;
      end
    endcase
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (st_q)
      RUN: begin
        if (mem_acc && bus.mem_busy_i) begin
          st_d  = MEM_WAIT;
          cnt_d = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_busy_i) begin
          if (cnt_q != TMO) cnt_d = cnt_q + CW'(1);
          if (cnt_d == TMO) err_d = 1'b1;
        end else begin
          st_d  = RUN;
          cnt_d = '0;
        end
      end
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      st_q  <= RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.stall_o    = stall;
  assign bus.bubble_o   = bubble;
  assign bus.ExMem_rd_o = mem_q.rd;
  assign bus.ExMem_Wb_o = mem_q.wb;
  assign bus.MemWb_rd_o = wb_q.rd;
  assign bus.MemWb_Wb_o = wb_q.wb;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: per-cycle expected outputs are
// queued by the driver and checked by an independent negedge monitor.
module tb_hazard_tag_pipe;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wb;
    logic       mr;
    logic       mw;
    logic       urt;
  } id_t;

  typedef struct packed {
    logic       st;
    logic       bu;
    logic [4:0] xrd;
    logic       xwb;
    logic [4:0] mrd;
    logic       mwb;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t q[$];

  hazard_tag_pipe_if #(.RA_W(5)) bus ();

  hazard_tag_pipe #(
    .RA_W(5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_t mk_id(
    input int rs, input int rt, input int rd,
    input bit wb, input bit mr, input bit mw, input bit urt
  );
    id_t r;
    r.rs  = 5'(rs);
    r.rt  = 5'(rt);
    r.rd  = 5'(rd);
    r.wb  = wb;
    r.mr  = mr;
    r.mw  = mw;
    r.urt = urt;
    return r;
  endfunction

  function automatic exp_t mk_e(
    input bit st, input bit bu,
    input int xrd, input bit xwb,
    input int mrd, input bit mwb, input bit err
  );
    exp_t r;
    r.st  = st;
    r.bu  = bu;
    r.xrd = 5'(xrd);
    r.xwb = xwb;
    r.mrd = 5'(mrd);
    r.mwb = mwb;
    r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_o",    int'(bus.stall_o),    int'(e.st));
      chk("bubble_o",   int'(bus.bubble_o),   int'(e.bu));
      chk("ExMem_rd_o", int'(bus.ExMem_rd_o), int'(e.xrd));
      chk("ExMem_Wb_o", int'(bus.ExMem_Wb_o), int'(e.xwb));
      chk("MemWb_rd_o", int'(bus.MemWb_rd_o), int'(e.mrd));
      chk("MemWb_Wb_o", int'(bus.MemWb_Wb_o), int'(e.mwb));
      chk("err_o",      int'(bus.err_o),      int'(e.err));
    end
  end

  task automatic step(
    input id_t id, input bit fl, input bit busy,
    input bit rst, input exp_t e
  );
    @(posedge clk);
    #1;
    rst_n              = rst;
    bus.id_rs_i        = id.rs;
    bus.id_rt_i        = id.rt;
    bus.id_rd_i        = id.rd;
    bus.id_wb_i        = id.wb;
    bus.id_memrd_i     = id.mr;
    bus.id_memwr_i     = id.mw;
    bus.id_use_rt_i    = id.urt;
    bus.flush_i        = fl;
    bus.mem_busy_i     = busy;
    q.push_back(e);
  endtask

  id_t nop, lw2, add3, sw2, sw2n, lw0, add0, lw5, add5;
  id_t lw7, swx, lw8, lw9, add9;
  exp_t z;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.id_rs_i = '0;
    bus.id_rt_i = '0;
    bus.id_rd_i = '0;
    bus.id_wb_i = 1'b0;
    bus.id_memrd_i = 1'b0;
    bus.id_memwr_i = 1'b0;
    bus.id_use_rt_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.mem_busy_i = 1'b0;

    nop  = mk_id(0, 0, 0, 0, 0, 0, 0);
    lw2  = mk_id(1, 2, 2, 1, 1, 0, 0);
    add3 = mk_id(2, 4, 3, 1, 0, 0, 1);
    sw2  = mk_id(1, 2, 0, 0, 0, 1, 1);
    sw2n = mk_id(1, 2, 0, 0, 0, 1, 0);
    lw0  = mk_id(1, 0, 0, 1, 1, 0, 0);
    add0 = mk_id(0, 0, 3, 1, 0, 0, 1);
    lw5  = mk_id(1, 5, 5, 1, 1, 0, 0);
    add5 = mk_id(5, 0, 6, 1, 0, 0, 1);
    lw7  = mk_id(1, 7, 7, 1, 1, 0, 0);
    swx  = mk_id(1, 9, 0, 0, 0, 1, 1);
    lw8  = mk_id(1, 8, 8, 1, 1, 0, 0);
    lw9  = mk_id(1, 9, 9, 1, 1, 0, 0);
    add9 = mk_id(9, 0, 10, 1, 0, 0, 1);
    z    = mk_e(0, 0, 0, 0, 0, 0, 0);

    // reset state
    step(nop, 0, 0, 0, z);
    step(nop, 0, 0, 1, z);

    // load-use on rs, then forwarding tags
    step(lw2,  0, 0, 1, z);
    step(add3, 0, 0, 1, mk_e(1, 1, 0, 0, 0, 0, 0));
    step(add3, 0, 0, 1, mk_e(0, 0, 2, 1, 0, 0, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 0, 0, 2, 1, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 3, 1, 0, 0, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 0, 0, 3, 1, 0));

    // load-use through rt of a store
    step(lw2, 0, 0, 1, z);
    step(sw2, 0, 0, 1, mk_e(1, 1, 0, 0, 0, 0, 0));
    step(sw2, 0, 0, 1, mk_e(0, 0, 2, 1, 0, 0, 0));
    step(nop, 0, 0, 1, mk_e(0, 0, 0, 0, 2, 1, 0));
    step(nop, 0, 0, 1, z);

    // rt not used: no hazard
    step(lw2,  0, 0, 1, z);
    step(sw2n, 0, 0, 1, z);
    step(nop,  0, 0, 1, mk_e(0, 0, 2, 1, 0, 0, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 0, 0, 2, 1, 0));
    step(nop,  0, 0, 1, z);

    // load to r0: no hazard, write still propagates
    step(lw0,  0, 0, 1, z);
    step(add0, 0, 0, 1, z);
    step(nop,  0, 0, 1, mk_e(0, 0, 0, 1, 0, 0, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 3, 1, 0, 1, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 0, 0, 3, 1, 0));

    // flush beats load-use
    step(lw5,  0, 0, 1, z);
    step(add5, 1, 0, 1, mk_e(0, 1, 0, 0, 0, 0, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 5, 1, 0, 0, 0));
    step(nop,  0, 0, 1, mk_e(0, 0, 0, 0, 5, 1, 0));

    // short memory wait
    step(lw7, 0, 0, 1, z);
    step(nop, 0, 0, 1, z);
    for (int i = 0; i < 3; i++)
      step(nop, 0, 1, 1, mk_e(1, 0, 7, 1, 0, 0, 0));
    step(nop, 0, 0, 1, mk_e(1, 0, 7, 1, 0, 0, 0));
    step(nop, 0, 0, 1, mk_e(0, 0, 7, 1, 0, 0, 0));
    step(nop, 0, 0, 1, mk_e(0, 0, 0, 0, 7, 1, 0));

    // store wait past the timeout
    step(swx, 0, 0, 1, z);
    step(nop, 0, 0, 1, z);
    for (int i = 0; i < 4; i++)
      step(nop, 0, 1, 1, mk_e(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      step(nop, 0, 1, 1, mk_e(1, 0, 0, 0, 0, 0, 1));
    step(nop, 0, 0, 1, mk_e(1, 0, 0, 0, 0, 0, 1));
    step(nop, 0, 0, 1, mk_e(0, 0, 0, 0, 0, 0, 1));
    step(nop, 0, 0, 1, mk_e(0, 0, 0, 0, 0, 0, 1));

    // async reset during a wait with a load-use pending
    step(lw8,  0, 0, 1, mk_e(0, 0, 0, 0, 0, 0, 1));
    step(lw9,  0, 0, 1, mk_e(0, 0, 0, 0, 0, 0, 1));
    step(add9, 0, 1, 1, mk_e(1, 0, 8, 1, 0, 0, 1));
    step(add9, 0, 1, 1, mk_e(1, 0, 8, 1, 0, 0, 1));
    step(add9, 0, 1, 0, z);
    step(add9, 0, 0, 1, z);
    step(nop,  0, 0, 1, z);
    step(nop,  0, 0, 1, mk_e(0, 0, 10, 1, 0, 0, 0));

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
